// File: rtl/recog_sequencer.sv
// Transaction sequencer for the speech-recognition datapath: SPI words -> sample buffer -> compare -> result readback.
// Optional build macro RECOG_ECHO_EN: loop each received word straight back to the SPI shifter while receiving.
module recog_sequencer #(
   parameter int NUM_SAMPLES = 2000,
   parameter int SAMPLE_W    = 10,
   parameter int ADDR_W      = 11,
   parameter int TIMEOUT_W   = 20
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ss,
   input  logic                word_valid,
   input  logic [31:0]         word_data,
   output logic                sample_we,
   output logic [ADDR_W-1:0]   sample_addr,
   output logic [SAMPLE_W-1:0] sample_data,
   output logic                cmp_start,
   input  logic                cmp_done,
   input  logic [3:0]          cmp_result,
   output logic                tx_load,
   output logic [31:0]         tx_word,
   input  logic                tx_done,
   output logic [3:0]          result,
   output logic                busy,
   output logic [2:0]          state_o,
   output logic [1:0]          err
);

   typedef enum logic [2:0] {
      IDLE    = 3'b000,
      RECV    = 3'b001,
      PROC    = 3'b010,
      WAIT_SS = 3'b011,
      XMIT    = 3'b100
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

   state_t               state, state_next;
   logic                 first;
   logic                 ss_q;
   logic [ADDR_W-1:0]    sample_cnt;
   logic [TIMEOUT_W-1:0] wd;
   logic [31:0]          tx_word_q;
   logic                 last_word;
   logic                 wd_expired;
   logic                 ss_rise;
   logic                 unused_bits;

   function automatic logic [31:0] status_word(input logic timeout, input logic [3:0] res,
                                               input logic [ADDR_W-1:0] cnt);
      status_word = {8'hA5, 3'b000, timeout, res, 16'(cnt)};
   endfunction

   assign last_word   = word_valid && (sample_cnt == LAST_ADDR);
   assign wd_expired  = &wd;
   assign ss_rise     = !ss_q && ss;
   assign unused_bits = ^word_data[31:SAMPLE_W];

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (ss) state_next = RECV;
         // the final word beats a coincident ss drop
         RECV:    if (last_word) state_next = PROC;
                  else if (!ss) state_next = IDLE;
         PROC:    if (cmp_done || wd_expired) state_next = WAIT_SS;
         WAIT_SS: if (ss_rise) state_next = XMIT;
         XMIT:    if (tx_done || !ss) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      sample_we   = (state == RECV) && word_valid;
      sample_addr = sample_cnt;
      sample_data = word_data[SAMPLE_W-1:0];
      cmp_start   = (state == PROC) && first;
      busy        = (state != IDLE);
      state_o     = state;
`ifdef RECOG_ECHO_EN
      tx_load = ((state == XMIT) && first) || sample_we;
      tx_word = sample_we ? word_data : tx_word_q;
`else
      tx_load = (state == XMIT) && first;
      tx_word = tx_word_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         first      <= 1'b0;
         ss_q       <= 1'b0;
         sample_cnt <= '0;
         wd         <= '0;
         result     <= 4'h0;
         err        <= 2'b00;
         tx_word_q  <= 32'h0;
      end else begin
         state <= state_next;
         first <= (state_next != state);
         ss_q  <= ss;
         case (state)
            IDLE: begin
               sample_cnt <= '0;
               if (ss) err <= 2'b00;
            end
            RECV: begin
               wd <= '0;
               if (word_valid) sample_cnt <= sample_cnt + 1'b1;
               if (!last_word && !ss) err[0] <= 1'b1;
`ifdef RECOG_ECHO_EN
               if (word_valid) tx_word_q <= word_data;
`endif
            end
            PROC: begin
               wd <= wd + 1'b1;
               if (cmp_done) begin
                  result <= cmp_result;
               end else if (wd_expired) begin
                  result <= 4'hF;
                  err[1] <= 1'b1;
               end
            end
            WAIT_SS: if (ss_rise) tx_word_q <= status_word(err[1], result, sample_cnt);
            default: ;
         endcase
      end
   end

endmodule
